// File: rtl/vec_req_arbiter_if.sv
// Requestor-vector and memory-port bundle for vec_req_arbiter.
// The master side drives requests and memory ready; the slave side is the arbiter.
interface vec_req_arbiter_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int IDX_W = (N <= 2) ? 1 : $clog2(N)
);
    logic [N-1:0]     io_requestor_req_valid;
    logic [N*W-1:0]   io_requestor_req_bits;
    logic [N-1:0]     io_requestor_req_last;
    logic [N-1:0]     io_requestor_req_ready;
    logic             io_mem_valid;
    logic [W-1:0]     io_mem_bits;
    logic             io_mem_last;
    logic [IDX_W-1:0] io_mem_idx;
    logic             io_mem_ready;

    modport master (
        output io_requestor_req_valid, io_requestor_req_bits, io_requestor_req_last, io_mem_ready,
        input  io_requestor_req_ready, io_mem_valid, io_mem_bits, io_mem_last, io_mem_idx
    );

    modport slave (
        input  io_requestor_req_valid, io_requestor_req_bits, io_requestor_req_last, io_mem_ready,
        output io_requestor_req_ready, io_mem_valid, io_mem_bits, io_mem_last, io_mem_idx
    );
endinterface

// File: rtl/vec_req_arbiter.sv
// N-way request arbiter (fixed or round-robin) with burst locking and a
// registered single-entry output stage toward the memory port.
module vec_req_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    vec_req_arbiter_if.slave   io
);
    localparam int IDX_W = (N <= 2) ? 1 : $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] lock_idx_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic             mem_valid_r;
    logic [W-1:0]     mem_bits_r;
    logic             mem_last_r;
    logic [IDX_W-1:0] mem_idx_r;

    logic             can_load_s;
    logic             gnt_found_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic [N-1:0]     ready_s;
    logic             accept_s;
    logic [W-1:0]     sel_bits_s;
    logic             sel_last_s;

    assign can_load_s = !mem_valid_r || io.io_mem_ready;

    // Winner selection; later loop iterations overwrite earlier ones, so loop order encodes priority.
    always_comb begin : grant_sel
        int cand;
        cand        = 0;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        if (state_r == ST_LOCKED) begin
            gnt_found_s = io.io_requestor_req_valid[lock_idx_r];
            gnt_idx_s   = lock_idx_r;
        end else if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                gnt_found_s = gnt_found_s | io.io_requestor_req_valid[i];
                gnt_idx_s   = io.io_requestor_req_valid[i] ? IDX_W'(i) : gnt_idx_s;
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                cand        = (int'(rr_ptr_r) + k) % N;
                gnt_found_s = gnt_found_s | io.io_requestor_req_valid[cand[IDX_W-1:0]];
                gnt_idx_s   = io.io_requestor_req_valid[cand[IDX_W-1:0]] ? cand[IDX_W-1:0] : gnt_idx_s;
            end
        end
    end

    // One-hot ready toward the winner, suppressed during reset and while the output is stalled.
    always_comb begin
        ready_s = '0;
        if (reset && can_load_s && gnt_found_s) begin
            ready_s[gnt_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s   = |(io.io_requestor_req_valid & ready_s);
    assign sel_bits_s = io.io_requestor_req_bits[int'(gnt_idx_s)*W +: W];
    assign sel_last_s = io.io_requestor_req_last[gnt_idx_s];

    // Output register, lock FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            lock_idx_r  <= '0;
            rr_ptr_r    <= IDX_W'(N - 1);
            mem_valid_r <= 1'b0;
            mem_bits_r  <= '0;
            mem_last_r  <= 1'b0;
            mem_idx_r   <= '0;
        end else if (accept_s) begin
            mem_valid_r <= 1'b1;
            mem_bits_r  <= sel_bits_s;
            mem_last_r  <= sel_last_s;
            mem_idx_r   <= gnt_idx_s;
            case (state_r)
                ST_IDLE: begin
                    if (!sel_last_s) begin
                        state_r    <= ST_LOCKED;
                        lock_idx_r <= gnt_idx_s;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (sel_last_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            if (MODE == 1 && sel_last_s) begin
                rr_ptr_r <= gnt_idx_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else if (io.io_mem_ready) begin
            mem_valid_r <= 1'b0;
        end else begin
            mem_valid_r <= mem_valid_r;
        end
    end

    assign io.io_requestor_req_ready = ready_s;
    assign io.io_mem_valid           = mem_valid_r;
    assign io.io_mem_bits            = mem_bits_r;
    assign io.io_mem_last            = mem_last_r;
    assign io.io_mem_idx             = mem_idx_r;
endmodule

// File: tb/tb_vec_req_arbiter.sv
// Scoreboard bench: stimulus pushes expected beats, per-DUT monitors pop and
// compare whenever a beat drains. dut_a runs fixed priority, dut_b round-robin.
module tb_vec_req_arbiter;
    typedef logic [10:0] beat_t;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    beat_t qa[$];
    beat_t qb[$];

    vec_req_arbiter_if #(.N(4), .W(8)) ia ();
    vec_req_arbiter_if #(.N(4), .W(8)) ib ();

    vec_req_arbiter #(.N(4), .W(8), .MODE(0)) dut_a (.clk(clk), .reset(reset), .io(ia.slave));
    vec_req_arbiter #(.N(4), .W(8), .MODE(1)) dut_b (.clk(clk), .reset(reset), .io(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] v, input logic [31:0] b, input logic [3:0] l);
        ia.io_requestor_req_valid = v;
        ia.io_requestor_req_bits  = b;
        ia.io_requestor_req_last  = l;
    endtask

    task automatic drive_b(input logic [3:0] v, input logic [31:0] b, input logic [3:0] l);
        ib.io_requestor_req_valid = v;
        ib.io_requestor_req_bits  = b;
        ib.io_requestor_req_last  = l;
    endtask

    always @(negedge clk) begin : mon_a
        beat_t e;
        if (reset && ia.io_mem_valid && ia.io_mem_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon_a: unexpected beat %0h", {ia.io_mem_bits, ia.io_mem_last, ia.io_mem_idx});
            end else begin
                e = qa.pop_front();
                chk("mon_a_beat", 32'({ia.io_mem_bits, ia.io_mem_last, ia.io_mem_idx}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t e;
        if (reset && ib.io_mem_valid && ib.io_mem_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon_b: unexpected beat %0h", {ib.io_mem_bits, ib.io_mem_last, ib.io_mem_idx});
            end else begin
                e = qb.pop_front();
                chk("mon_b_beat", 32'({ib.io_mem_bits, ib.io_mem_last, ib.io_mem_idx}), 32'(e));
            end
        end
    end

    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        reset = 1'b0;
        drive_a(4'hF, 32'h0, 4'hF);
        drive_b(4'hF, 32'h0, 4'hF);
        ia.io_mem_ready = 1'b1;
        ib.io_mem_ready = 1'b1;
        #3;
        chk("rdy_a_in_reset", 32'(ia.io_requestor_req_ready), 32'h0);
        chk("rdy_b_in_reset", 32'(ib.io_requestor_req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_a(4'h0, 32'h0, 4'h0);
        drive_b(4'h0, 32'h0, 4'h0);
        #2;
        chk("rst_valid", 32'(ia.io_mem_valid), 32'h0);
        chk("rst_bits",  32'(ia.io_mem_bits),  32'h0);
        chk("rst_last",  32'(ia.io_mem_last),  32'h0);
        chk("rst_idx",   32'(ia.io_mem_idx),   32'h0);
        tick();

        // Fixed priority: requestor 2 beats 0, then 0 alone.
        drive_a(4'b0101, 32'h0033_0011, 4'hF);
        #2 chk("fix_rdy_hi", 32'(ia.io_requestor_req_ready), 32'h4);
        qa.push_back({8'h33, 1'b1, 2'd2});
        tick();
        drive_a(4'b0001, 32'h0033_0011, 4'hF);
        #2 chk("fix_rdy_lo", 32'(ia.io_requestor_req_ready), 32'h1);
        qa.push_back({8'h11, 1'b1, 2'd0});
        tick();
        drive_a(4'b0000, 32'h0, 4'h0);
        #2 chk("idle_rdy", 32'(ia.io_requestor_req_ready), 32'h0);
        tick();

        // Burst lock on requestor 1 while requestor 3 (higher priority) waits.
        drive_a(4'b0010, 32'h0000_A000, 4'b0000);
        #2 chk("burst_rdy0", 32'(ia.io_requestor_req_ready), 32'h2);
        qa.push_back({8'hA0, 1'b0, 2'd1});
        tick();
        drive_a(4'b1010, 32'h3C00_A100, 4'b1000);
        #2 chk("burst_rdy1", 32'(ia.io_requestor_req_ready), 32'h2);
        qa.push_back({8'hA1, 1'b0, 2'd1});
        tick();
        drive_a(4'b1000, 32'h3C00_0000, 4'b1000);
        for (int c = 0; c < 2; c++) begin
            #2 chk("burst_gap_rdy", 32'(ia.io_requestor_req_ready), 32'h0);
            tick();
        end
        drive_a(4'b1010, 32'h3C00_A200, 4'b1010);
        #2 chk("burst_rdy2", 32'(ia.io_requestor_req_ready), 32'h2);
        qa.push_back({8'hA2, 1'b1, 2'd1});
        tick();
        drive_a(4'b1000, 32'h3C00_0000, 4'b1000);
        #2 chk("post_burst_rdy", 32'(ia.io_requestor_req_ready), 32'h8);
        qa.push_back({8'h3C, 1'b1, 2'd3});
        tick();
        drive_a(4'b0000, 32'h0, 4'h0);
        tick();

        // Backpressure: 0x55 held for 5 stalled cycles, then drain+load together.
        ia.io_mem_ready = 1'b0;
        drive_a(4'b0001, 32'h0000_0055, 4'hF);
        #2 chk("bp_load_rdy", 32'(ia.io_requestor_req_ready), 32'h1);
        qa.push_back({8'h55, 1'b1, 2'd0});
        tick();
        drive_a(4'b0100, 32'h0077_0000, 4'hF);
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("bp_rdy",   32'(ia.io_requestor_req_ready), 32'h0);
            chk("bp_bits",  32'(ia.io_mem_bits),  32'h55);
            chk("bp_valid", 32'(ia.io_mem_valid), 32'h1);
            chk("bp_idx",   32'(ia.io_mem_idx),   32'h0);
            tick();
        end
        ia.io_mem_ready = 1'b1;
        #2 chk("bp_release_rdy", 32'(ia.io_requestor_req_ready), 32'h4);
        qa.push_back({8'h77, 1'b1, 2'd2});
        tick();
        drive_a(4'b0000, 32'h0, 4'h0);
        #2;
        chk("no_bubble_valid", 32'(ia.io_mem_valid), 32'h1);
        chk("no_bubble_idx",   32'(ia.io_mem_idx),   32'h2);
        tick();

        // Round robin, all four requesting single beats continuously.
        drive_b(4'hF, 32'hB3B2_B1B0, 4'hF);
        for (int k = 0; k < 5; k++) begin
            #2 chk("rr_rdy", 32'(ib.io_requestor_req_ready), 32'(4'b0001 << rr_seq[k]));
            qb.push_back({8'hB0 + {6'd0, rr_seq[k]}, 1'b1, rr_seq[k]});
            tick();
        end
        drive_b(4'h0, 32'h0, 4'h0);
        tick();

        // Lock requestor 2 with a held beat, then reset.
        drive_b(4'b0100, 32'h0090_0000, 4'b0000);
        #2 chk("lock2_rdy", 32'(ib.io_requestor_req_ready), 32'h4);
        tick();
        drive_b(4'b0100, 32'h0091_0000, 4'b0100);
        reset = 1'b0;
        #2;
        chk("held_valid", 32'(ib.io_mem_valid), 32'h1);
        chk("held_bits",  32'(ib.io_mem_bits),  32'h90);
        chk("rst_mid_rdy", 32'(ib.io_requestor_req_ready), 32'h0);
        tick();
        reset = 1'b1;
        drive_b(4'hF, 32'hB3B2_B1B0, 4'hF);
        #2;
        chk("post_rst_valid", 32'(ib.io_mem_valid), 32'h0);
        chk("post_rst_rdy",   32'(ib.io_requestor_req_ready), 32'h1);
        qb.push_back({8'hB0, 1'b1, 2'd0});
        tick();
        drive_b(4'h0, 32'h0, 4'h0);
        tick();
        tick();

        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vec_req_arbiter.md
# vec_req_arbiter

Parametrised N-way request arbiter with a registered memory-side output stage. It replaces the fixed 4-way, 1-bit, combinational priority mux in front of the memory port. It adds data payload, selectable fixed or round-robin priority, multi-beat burst locking, and ready/valid backpressure from memory. It sits between the requestor vector and the single memory request port.

## Interface
- N, default 4: requestor count, must be ≥ 2.
- W, default 8: payload width per beat, must be ≥ 1.
- MODE, default 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- IDX_W, derived = max(1, ceil(log2 N)): width of the grant index.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low; state clears on a clk edge where reset = 0.
- io_requestor_req_valid  in  N  per-requestor request valid; bit i belongs to requestor i.
- io_requestor_req_bits  in  N*W  payloads; requestor i occupies bits [i*W +: W].
- io_requestor_req_last  in  N  per-requestor end-of-burst flag.
- io_requestor_req_ready  out  N  per-requestor accept; at most one bit high per cycle.
- io_mem_valid  out  1  output register holds a beat.
- io_mem_bits  out  W  registered payload.
- io_mem_last  out  1  registered last flag.
- io_mem_idx  out  IDX_W  index of the requestor that sourced the beat.
- io_mem_ready  in  1  memory accepts the beat when high together with io_mem_valid.

## Operation
- Output stage: a single register holds {valid, bits, last, idx}.
  - It can load when empty or when draining in the same cycle: can_load = !io_mem_valid || io_mem_ready.
- Grant selection (combinational, one winner g among valid requestors):
  - MODE 0: highest index with valid = 1.
  - MODE 1: first valid index scanning rr_ptr+1, rr_ptr+2, … mod N.
- io_requestor_req_ready[i] = can_load && (i == g), with the lock rule below applied.
- Accept happens when valid[i] && ready[i] are both high.
  - On accept, the output register loads bits, last and idx = i, and sets valid.
  - On drain without accept, valid clears.
- Lock state machine:
  - IDLE → LOCKED(i): on accepting a beat from i with last = 0.
  - LOCKED(i): only requestor i can be granted; all other ready bits are 0, even when i is not valid. Lock is held indefinitely until i presents its last beat.
  - LOCKED(i) → IDLE: on accepting a beat from i with last = 1.
  - A single-beat request (last = 1) never leaves IDLE.
- Round-robin pointer (MODE 1 only): rr_ptr ← i on accept of a beat from i with last = 1. The pointer is not updated for mid-burst beats. In MODE 0, rr_ptr is unused.
- No valid requestor, or can_load = 0: all ready bits are 0 and no state changes, except drain.
- A requestor may drop valid at any time before accept; there is no stickiness beyond the lock.

## Timing
- Reset values:
  - io_mem_valid = 0, io_mem_bits = 0, io_mem_last = 0, io_mem_idx = 0.
  - State = IDLE.
  - rr_ptr = N-1, so index 0 has first round-robin priority.
  - io_requestor_req_ready = 0 during reset.
- Latency: a beat accepted at edge t appears on io_mem_* from the cycle after edge t until drained.
- Throughput: 1 beat/cycle while io_mem_ready = 1. Simultaneous drain and load in one cycle is required; no bubble.
- io_mem_valid = 1 with io_mem_ready = 0: io_mem_* are held stable, and all ready bits are 0.
- io_requestor_req_ready depends combinationally on io_mem_ready. There is no combinational path from io_requestor_* to io_mem_*.
- Reset asserted mid-burst or with a held beat: the beat is discarded, the lock is released and rr_ptr returns to N-1 on that edge.

## Test plan
- MODE 0, N=4, W=8, io_mem_ready=1; valid=4'b0101, bits of requestor 0 = 0x11, requestor 2 = 0x33, last all 1 → ready=4'b0100; next cycle io_mem_valid=1, bits=0x33, idx=2; then ready=4'b0001 → bits=0x11, idx=0.
- MODE 1, all four valid with last=1, continuous → io_mem_idx sequence 0,1,2,3,0, one beat per cycle.
- Burst lock: requestor 1 sends 3 beats 0xA0, 0xA1, 0xA2 with last only on the third, and requestor 3 valid throughout.
  - MODE 0 → idx stays 1 for three consecutive beats, then 3 is granted.
  - Requestor 1 dropping valid for 2 cycles mid-burst → ready=0 for all, and requestor 3 is not granted.
- Backpressure: beat 0x55 held while io_mem_ready=0 for 5 cycles → io_mem_* stable and all ready bits 0. Raising io_mem_ready with a second requestor valid → drain and load in the same cycle, with no idle cycle.
- Reset (reset=0 for 1 cycle) while LOCKED(2) with io_mem_valid=1 → io_mem_valid=0, IDLE, rr_ptr=3. Next MODE 1 grant goes to requestor 0 if valid.
